// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage.
// Contents:
//   fetch_state_e - fetch controller states (reset wait, run, drain)
//   INSTR_W       - instruction word width
//   PC_STEP       - byte distance between sequential instructions
//   NOP_INSTR     - word presented to decode when no instruction is valid
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    StRstWait,
    StRun,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Bus bundle of the fetch stage: instruction-memory request/response, redirect input,
// decode-side valid/ready output and the busy status.
// Modports:
//   master - the fetch unit (drives requests, decode outputs, status)
//   slave  - the environment (memory, branch unit, decode)
interface mips_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  import mips_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               fetch_busy;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, fetch_busy,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, fetch_busy,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           out_ready
  );

endinterface

// File: rtl/mips_fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instruction} entries.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (empties the FIFO)
//   flush      - synchronous empty; wins over push/pop in the same cycle
//   push, push_data - write an entry (ignored when full unless a pop happens too)
//   pop        - remove the head entry (ignored when empty)
//   head_data  - current head entry (meaningless while empty)
//   count, full, empty - occupancy status
module mips_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage feeding the IF/ID decode stage.
// Issues sequential fetches to a variable-latency instruction memory, buffers returned
// words with their PCs in a prefetch FIFO, and hands them to decode over valid/ready.
// A redirect flushes the FIFO and marks every in-flight response for discard.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - mips_fetch_unit_if.master: imem request/response, redirect,
//                decode output (out_valid/out_ready/out_pc/out_instr), fetch_busy
module mips_fetch_unit import mips_pkg::*; #(
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       FIFO_DEPTH      = 4,
  parameter int unsigned       MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
  input logic              clk,
  input logic              rst_n,
  mips_fetch_unit_if.master bus
);

  localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W   = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [OUT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic               issue_ok, req_valid, req_fire, rsp_fire;
  logic               fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [SUM_W-1:0]   committed;
  logic [ADDR_W-1:0]  redirect_base;

  // Slots already promised to kept in-flight responses count as occupied, so a
  // response always finds room and memory never has to be back-pressured.
  assign committed = SUM_W'(fifo_count) + SUM_W'(outstanding_q) - SUM_W'(drop_cnt_q);

  assign issue_ok = (state_q != StRstWait) &&
                    (outstanding_q < OUT_W'(MAX_OUTSTANDING)) &&
                    (committed < SUM_W'(FIFO_DEPTH));

  // Redirect must suppress the request in its own cycle.
  assign req_valid     = issue_ok && !bus.redirect_valid;
  assign req_fire      = req_valid && bus.imem_req_ready;
  assign rsp_fire      = bus.imem_rsp_valid;
  assign fifo_pop      = !fifo_empty && bus.out_ready;
  assign redirect_base = bus.redirect_pc & ~ADDR_W'(3);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    fifo_push     = 1'b0;
    fifo_flush    = 1'b0;
    outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(rsp_fire);

    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path,
      // including a response arriving right now.
      fifo_flush = 1'b1;
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      if (rsp_fire) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - OUT_W'(1);
        end else begin
          fifo_push = !fifo_full || fifo_pop;
          rsp_pc_d  = rsp_pc_q + ADDR_W'(PC_STEP);
        end
      end
    end

    unique case (state_q)
      StRstWait: state_d = bus.redirect_valid && (drop_cnt_d != '0) ? StDrain : StRun;
      StRun,
      StDrain:   state_d = (drop_cnt_d != '0) ? StDrain : StRun;
      default:   state_d = StRstWait;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRstWait;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  mips_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data ({rsp_pc_q, bus.imem_rsp_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.out_valid      = !fifo_empty;
  assign bus.out_pc         = fifo_empty ? '0 : fifo_head[ENTRY_W-1:INSTR_W];
  assign bus.out_instr      = fifo_empty ? NOP_INSTR : fifo_head[INSTR_W-1:0];
  assign bus.fetch_busy     = (outstanding_q != '0) || (drop_cnt_q != '0);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized scoreboard bench for mips_fetch_unit. A memory model answers requests in
// order after a random latency; the expected decode stream is a sequence of PCs that
// restarts at each redirect target (word aligned), with instr = memory word at that PC.
module tb_mips_fetch_unit;
  import mips_pkg::*;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mips_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mips_fetch_unit #(
    .ADDR_W          (ADDR_W),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem_tbl [64];
  req_t        mq [$];
  logic [31:0] seg_q [$];
  int          cyc = 0, last_due = 0, tb_out = 0, rsp_total = 0, pops = 0, cap_seen = 0;
  bit          acc_f = 0, rsp_f = 0;
  logic [31:0] acc_addr = '0;
  int          lat_min = 1, lat_max = 1, rdy_pct = 100, ordy_pct = 100;
  bit          redir_pend = 0;
  int          redir_mode = 0;
  logic [31:0] redir_tgt = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_tbl[a[7:2]];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(negedge clk);
      #3;
    end
  endtask

  // Memory, decode and branch-unit environment. Effects of the previous edge are applied
  // first so tb_out always mirrors accepted-but-unreturned requests at sample time.
  initial begin : env
    bit go;
    int d;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mq.delete();
        tb_out = 0; acc_f = 0; rsp_f = 0; last_due = 0;
        bus.imem_rsp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.out_ready      = 1'b0;
      end else begin
        if (rsp_f) begin
          void'(mq.pop_front());
          tb_out--;
          rsp_total++;
        end
        if (acc_f) begin
          d = cyc + int'($urandom_range(lat_max, lat_min)) - 1;
          if (d < last_due) d = last_due;
          last_due = d;
          mq.push_back('{acc_addr, d});
          tb_out++;
        end
        bus.imem_rsp_valid = (mq.size() > 0) && (mq[0].due <= cyc);
        bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_word(mq[0].addr) : $urandom();
        bus.imem_req_ready = $urandom_range(99) < rdy_pct;
        bus.out_ready      = $urandom_range(99) < ordy_pct;
        bus.redirect_valid = 1'b0;
        if (redir_pend) begin
          go = 1'b0;
          case (redir_mode)
            1:       go = bus.imem_rsp_valid && bus.out_valid && bus.out_ready;
            2:       go = (tb_out == MAX_OUT);
            default: go = 1'b1;
          endcase
          if (go) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = redir_tgt;
            seg_q.push_back(redir_tgt & ~32'h3);
            redir_pend = 1'b0;
          end
        end
        #1;
        acc_f    = bus.imem_req_valid && bus.imem_req_ready;
        acc_addr = bus.imem_req_addr;
        rsp_f    = bus.imem_rsp_valid;
      end
    end
  end

  // Scoreboard monitor: compares every decode handshake with the expected stream.
  initial begin : mon
    logic [31:0] exp_pc;
    bit          chk_empty;
    exp_pc    = RESET_PC;
    chk_empty = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        exp_pc    = RESET_PC;
        chk_empty = 1'b0;
        seg_q.delete();
      end else begin
        if (chk_empty) begin
          chk("flushed_after_redirect", bus.out_valid, 0);
          chk_empty = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
          chk("out_pc", bus.out_pc, exp_pc);
          chk("out_instr", bus.out_instr, mem_word(exp_pc));
          exp_pc += 32'd4;
          pops++;
        end
        if (bus.redirect_valid) begin
          chk("req_gated_by_redirect", bus.imem_req_valid, 0);
          chk("segment_queued", seg_q.size() > 0, 1);
          if (seg_q.size() > 0) exp_pc = seg_q.pop_front();
          chk_empty = 1'b1;
        end
        chk("fetch_busy", bus.fetch_busy, tb_out != 0);
        chk("outstanding_cap", tb_out <= MAX_OUT, 1);
        if (bus.imem_req_valid) chk("req_below_cap", tb_out < MAX_OUT, 1);
        chk("req_addr_aligned", bus.imem_req_addr[1:0], 0);
        if (tb_out == MAX_OUT && !bus.imem_req_valid) cap_seen++;
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_req_addr", bus.imem_req_addr, RESET_PC);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_fetch_busy", bus.fetch_busy, 0);
    cycle(2);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("rst_wait_no_req", bus.imem_req_valid, 0);
    cycle(1);
    chk("first_req_valid", bus.imem_req_valid, 1);
    chk("first_req_addr", bus.imem_req_addr, RESET_PC);
  endtask

  task automatic wait_fire(input string nm);
    for (int k = 0; k < 200 && redir_pend; k++) cycle(1);
    chk(nm, redir_pend, 0);
  endtask

  task automatic wait_out_valid(input string nm);
    for (int k = 0; k < 50 && !bus.out_valid; k++) cycle(1);
    chk(nm, bus.out_valid, 1);
  endtask

  initial begin : main
    int p0, r0;
    for (int i = 0; i < 64; i++) mem_tbl[i] = $urandom();
    mem_tbl[3] = 32'h214A0001;

    // Sequential stream, 1-cycle memory, decode always ready.
    #1;
    apply_reset();
    for (int k = 0; k < 20 && !bus.imem_rsp_valid; k++) cycle(1);
    chk("first_rsp_seen", bus.imem_rsp_valid, 1);
    chk("no_bypass", bus.out_valid, 0);
    cycle(5);
    p0 = pops;
    cycle(16);
    chk("steady_throughput", pops - p0, 16);

    // Decode stalled: exactly DEPTH words buffered, requests stop.
    ordy_pct = 0;
    apply_reset();
    r0 = rsp_total;
    cycle(20);
    chk("stall_buffered", rsp_total - r0, DEPTH);
    chk("stall_req_off", bus.imem_req_valid, 0);
    chk("stall_no_outstanding", tb_out, 0);
    chk("stall_head_pc", bus.out_pc, RESET_PC);
    ordy_pct = 100;
    p0 = pops;
    cycle(12);
    chk("stall_release_drain", pops - p0 >= DEPTH, 1);

    // 3-cycle memory: outstanding capped at MAX_OUT.
    lat_min = 3; lat_max = 3;
    cap_seen = 0;
    cycle(40);
    chk("cap_reached", cap_seen > 0, 1);

    // Redirect to 0x0C with two in flight.
    redir_tgt = 32'h0C; redir_mode = 2; redir_pend = 1'b1;
    wait_fire("redir_0c_fired");
    cycle(1);
    chk("redir_0c_busy", bus.fetch_busy, 1);
    chk("redir_0c_addr", bus.imem_req_addr, 32'h0C);
    wait_out_valid("redir_0c_valid");
    chk("redir_0c_pc", bus.out_pc, 32'h0C);
    chk("redir_0c_instr", bus.out_instr, 32'h214A0001);

    // Redirect coinciding with a response and a pop.
    lat_min = 1; lat_max = 1;
    cycle(6);
    redir_tgt = 32'h40; redir_mode = 1; redir_pend = 1'b1;
    wait_fire("redir_coincide_fired");
    cycle(10);

    // Unaligned target.
    redir_tgt = 32'h13; redir_mode = 0; redir_pend = 1'b1;
    wait_fire("redir_13_fired");
    cycle(1);
    chk("redir_13_addr", bus.imem_req_addr, 32'h10);
    wait_out_valid("redir_13_valid");
    chk("redir_13_pc", bus.out_pc, 32'h10);

    // Reset while draining.
    lat_min = 3; lat_max = 3;
    cycle(8);
    redir_tgt = 32'h80; redir_mode = 2; redir_pend = 1'b1;
    wait_fire("redir_drain_fired");
    cycle(1);
    chk("drain_busy", bus.fetch_busy, 1);
    apply_reset();

    // Random traffic with occasional redirects, including near the address wrap.
    lat_min = 1; lat_max = 4; rdy_pct = 70; ordy_pct = 60;
    for (int n = 0; n < 1500; n++) begin
      cycle(1);
      if (!redir_pend && $urandom_range(39) == 0) begin
        redir_tgt  = ($urandom_range(7) == 0) ? 32'hFFFF_FFF4 : $urandom();
        redir_mode = 0;
        redir_pend = 1'b1;
      end
    end
    ordy_pct = 100;
    p0 = pops;
    cycle(30);
    chk("final_progress", pops > p0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
